// File: rtl/if_prefetch.sv
// Instruction-fetch prefetcher: credit-limited in-order requests, FIFO of fetched
// instructions, and redirect flush with stale-response dropping. Option: IF_MISALIGN_CHECK_EN.
module if_prefetch #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic            fetch_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1'b1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
    localparam logic [CW:0]     DEPTH_L  = (CW+1)'(DEPTH);
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(3'd4);

    logic [XLEN-1:0] instr_q [DEPTH];
    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d, outst_q, outst_d, drop_q, drop_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
    logic            halted_q, halted_d, fetch_err_q, fetch_err_d;

    logic            credit_s, req_valid_s, req_fire_s, rsp_keep_s, pop_s;
    logic [CW-1:0]   rsp_in_s;
    logic [XLEN-1:0] redir_tgt_s;

    // Request credit covers both buffered and in-flight instructions, so the FIFO never overflows.
    assign credit_s    = ({1'b0, count_q} + {1'b0, outst_q}) < DEPTH_L;
    assign req_valid_s = rst & credit_s & ~halted_q & ~redirect_valid;
    assign req_fire_s  = req_valid_s & imem_req_ready;
    assign rsp_keep_s  = imem_rsp_valid & (drop_q == CNT_ZERO);
    assign rsp_in_s    = imem_rsp_valid ? CNT_ONE : CNT_ZERO;
    assign pop_s       = (count_q != CNT_ZERO) & if_ready;

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = fetch_pc_q;
    assign if_valid       = (count_q != CNT_ZERO);
    assign if_instr       = instr_q[rd_ptr_q];
    assign if_pc          = pc_q[rd_ptr_q];
    assign fetch_err      = fetch_err_q;

    // Redirect target and misalignment handling
    always_comb begin
        redir_tgt_s = redirect_pc;
        halted_d    = halted_q;
        fetch_err_d = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
        if (redirect_valid) begin
            halted_d    = (redirect_pc[1:0] != 2'b00);
            fetch_err_d = (redirect_pc[1:0] != 2'b00);
        end else begin
            halted_d    = halted_q;
            fetch_err_d = 1'b0;
        end
`else
        redir_tgt_s = redirect_pc & ~XLEN'(2'b11);
        halted_d    = 1'b0;
        fetch_err_d = 1'b0;
`endif
    end

    // Next-state for pointers, counters and PCs
    always_comb begin
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        if (redirect_valid) begin
            // Everything still in flight becomes stale; a response arriving now is already retired.
            count_d    = CNT_ZERO;
            wr_ptr_d   = {AW{1'b0}};
            rd_ptr_d   = {AW{1'b0}};
            fetch_pc_d = redir_tgt_s;
            rsp_pc_d   = redir_tgt_s;
            outst_d    = outst_q - rsp_in_s;
            drop_d     = outst_q - rsp_in_s;
        end else begin
            fetch_pc_d = req_fire_s ? fetch_pc_q + PC_STEP : fetch_pc_q;
            outst_d    = outst_q + (req_fire_s ? CNT_ONE : CNT_ZERO) - rsp_in_s;
            drop_d     = (imem_rsp_valid && (drop_q != CNT_ZERO)) ? drop_q - CNT_ONE : drop_q;
            wr_ptr_d   = rsp_keep_s ? wr_ptr_q + PTR_ONE : wr_ptr_q;
            rsp_pc_d   = rsp_keep_s ? rsp_pc_q + PC_STEP : rsp_pc_q;
            rd_ptr_d   = pop_s ? rd_ptr_q + PTR_ONE : rd_ptr_q;
            count_d    = count_q + (rsp_keep_s ? CNT_ONE : CNT_ZERO) - (pop_s ? CNT_ONE : CNT_ZERO);
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q     <= CNT_ZERO;
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            outst_q     <= CNT_ZERO;
            drop_q      <= CNT_ZERO;
            fetch_pc_q  <= RESET_PC;
            rsp_pc_q    <= RESET_PC;
            halted_q    <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            outst_q     <= outst_d;
            drop_q      <= drop_d;
            fetch_pc_q  <= fetch_pc_d;
            rsp_pc_q    <= rsp_pc_d;
            halted_q    <= halted_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    // FIFO storage, written at the tail for each kept response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= {XLEN{1'b0}};
                pc_q[i]    <= {XLEN{1'b0}};
            end
        end else if (rsp_keep_s && !redirect_valid) begin
            instr_q[wr_ptr_q] <= imem_rsp_data;
            pc_q[wr_ptr_q]    <= rsp_pc_q;
        end
    end
endmodule

// File: tb/tb_if_prefetch.sv
// Directed self-checking bench for if_prefetch with an in-order fixed-latency memory model.
module tb_if_prefetch;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid, if_ready;
    logic [31:0] if_instr, if_pc;
    logic        fetch_err;

    int tests = 0;
    int fails = 0;
    int mem_lat = 1;
    int cyc = 0;
    logic [31:0] rsp_addr_q[$];
    int          rsp_due_q[$];
    logic [31:0] req_log[$];

    if_prefetch #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory model: records accepted requests, answers in order after mem_lat cycles.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        forever begin
            @(negedge clk); #1;
            imem_rsp_valid = 1'b0;
            if (!rst) begin
                rsp_addr_q.delete(); rsp_due_q.delete(); req_log.delete();
            end else begin
                if (rsp_due_q.size() > 0 && rsp_due_q[0] <= cyc) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = data_of(rsp_addr_q[0]);
                    void'(rsp_addr_q.pop_front());
                    void'(rsp_due_q.pop_front());
                end
                if (imem_req_valid && imem_req_ready) begin
                    rsp_addr_q.push_back(imem_req_addr);
                    rsp_due_q.push_back(cyc + mem_lat);
                    req_log.push_back(imem_req_addr);
                end
            end
            cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input int lat);
        @(negedge clk);
        rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        if_ready = 1'b0; imem_req_ready = 1'b1; mem_lat = lat;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic pop_one(output logic got, output logic [31:0] pc, output logic [31:0] ins);
        got = 1'b0; pc = 32'h0; ins = 32'h0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (if_valid && if_ready) begin
                got = 1'b1; pc = if_pc; ins = if_instr;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; if_ready = 1'b0;
        imem_req_ready = 1'b1; mem_lat = 1;
        #3;
        tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
        tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL reset_if_valid: got %b expected 0", if_valid); end
        tests++; if (fetch_err !== 1'b0) begin fails++; $display("FAIL reset_fetch_err: got %b expected 0", fetch_err); end
        tests++; if (if_pc !== 32'h0 || if_instr !== 32'h0) begin fails++; $display("FAIL reset_if_out: got pc %h instr %h expected 0", if_pc, if_instr); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #2;
        tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin fails++; $display("FAIL reset_first_req: got v=%b addr=%h expected v=1 addr=0", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_sequential;
        logic got; logic [31:0] pc, ins;
        do_reset(1);
        if_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            pop_one(got, pc, ins);
            tests++; if (!got || pc !== 32'(4 * k)) begin fails++; $display("FAIL seq_pc[%0d]: got %h (valid %b) expected %h", k, pc, got, 32'(4 * k)); end
            tests++; if (ins !== data_of(32'(4 * k))) begin fails++; $display("FAIL seq_instr[%0d]: got %h expected %h", k, ins, data_of(32'(4 * k))); end
        end
        for (int k = 0; k < 5; k++) begin
            tests++; if (req_log.size() <= k || req_log[k] !== 32'(4 * k)) begin fails++; $display("FAIL seq_req[%0d]: log size %0d expected addr %h", k, req_log.size(), 32'(4 * k)); end
        end
    endtask

    task automatic test_backpressure;
        do_reset(1);
        repeat (12) @(negedge clk);
        #2;
        tests++; if (req_log.size() != 4) begin fails++; $display("FAIL bp_req_count: got %0d expected 4", req_log.size()); end
        tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL bp_req_valid: got %b expected 0", imem_req_valid); end
        tests++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== data_of(32'h0)) begin fails++; $display("FAIL bp_head_hold: got v=%b pc=%h instr=%h expected v=1 pc=0", if_valid, if_pc, if_instr); end
        if_ready = 1'b1;
        @(negedge clk);
        if_ready = 1'b0;
        repeat (6) @(negedge clk);
        #2;
        tests++; if (req_log.size() != 5 || req_log[4] !== 32'h10) begin fails++; $display("FAIL bp_one_more_req: got count %0d expected 5 with last 00000010", req_log.size()); end
        tests++; if (if_pc !== 32'h4 || imem_req_valid !== 1'b0) begin fails++; $display("FAIL bp_after_pop: got pc=%h req_valid=%b expected pc=4 req_valid=0", if_pc, imem_req_valid); end
    endtask

    task automatic test_redirect_drop;
        logic got; logic [31:0] pc, ins;
        do_reset(4);
        if_ready = 1'b1;
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        #2;
        tests++; if (req_log.size() != 3 || imem_req_valid !== 1'b0) begin fails++; $display("FAIL rd_outstanding: got %0d reqs, req_valid=%b expected 3 and 0", req_log.size(), imem_req_valid); end
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pop_one(got, pc, ins);
            tests++; if (!got || pc !== 32'h100 + 32'(4 * k) || ins !== data_of(32'h100 + 32'(4 * k))) begin fails++; $display("FAIL rd_pc[%0d]: got %h/%h expected %h", k, pc, ins, 32'h100 + 32'(4 * k)); end
        end
        tests++; if (req_log.size() < 4 || req_log[3] !== 32'h100) begin fails++; $display("FAIL rd_new_req: log size %0d expected 4th addr 00000100", req_log.size()); end
    endtask

    task automatic test_redirect_pop;
        logic got; logic [31:0] pc, ins;
        do_reset(1);
        if_ready = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin fails++; $display("FAIL rp_pop_head: got v=%b pc=%h expected v=1 pc=0", if_valid, if_pc); end
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        #2;
        tests++; if (imem_rsp_valid !== 1'b1 || imem_req_valid !== 1'b0) begin fails++; $display("FAIL rp_coincident: got rsp=%b req=%b expected rsp=1 req=0", imem_rsp_valid, imem_req_valid); end
        @(negedge clk);
        redirect_valid = 1'b0;
        tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL rp_flush: got if_valid %b expected 0", if_valid); end
        tests++; if (req_log.size() != 2) begin fails++; $display("FAIL rp_req_blocked: got %0d reqs expected 2", req_log.size()); end
        for (int k = 0; k < 2; k++) begin
            pop_one(got, pc, ins);
            tests++; if (!got || pc !== 32'h200 + 32'(4 * k) || ins !== data_of(32'h200 + 32'(4 * k))) begin fails++; $display("FAIL rp_pc[%0d]: got %h/%h expected %h", k, pc, ins, 32'h200 + 32'(4 * k)); end
        end
    endtask

    task automatic test_misalign;
        logic got; logic [31:0] pc, ins;
        do_reset(1);
        if_ready = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        @(negedge clk);
        redirect_valid = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
        #2;
        tests++; if (fetch_err !== 1'b1 || imem_req_valid !== 1'b0) begin fails++; $display("FAIL ma_err_pulse: got err=%b req=%b expected 1 and 0", fetch_err, imem_req_valid); end
        @(negedge clk);
        tests++; if (fetch_err !== 1'b0) begin fails++; $display("FAIL ma_err_once: got %b expected 0", fetch_err); end
        repeat (5) @(negedge clk);
        tests++; if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin fails++; $display("FAIL ma_halted: got req=%b if_valid=%b expected 0", imem_req_valid, if_valid); end
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        redirect_valid = 1'b0;
        pop_one(got, pc, ins);
        tests++; if (!got || pc !== 32'h200) begin fails++; $display("FAIL ma_resume: got %h expected 00000200", pc); end
`else
        #2;
        tests++; if (imem_req_addr !== 32'h100 || fetch_err !== 1'b0) begin fails++; $display("FAIL ma_align: got addr=%h err=%b expected 00000100 and 0", imem_req_addr, fetch_err); end
        pop_one(got, pc, ins);
        tests++; if (!got || pc !== 32'h100 || ins !== data_of(32'h100)) begin fails++; $display("FAIL ma_first_pc: got %h/%h expected 00000100", pc, ins); end
`endif
    endtask

    task automatic test_wrap;
        logic got; logic [31:0] pc, ins, exp_pc;
        do_reset(1);
        if_ready = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_pc = 32'hFFFF_FFF8 + 32'(4 * k);
            pop_one(got, pc, ins);
            tests++; if (!got || pc !== exp_pc || ins !== data_of(exp_pc)) begin fails++; $display("FAIL wrap_pc[%0d]: got %h/%h expected %h", k, pc, ins, exp_pc); end
        end
    endtask

    task automatic test_midstream_reset;
        logic got; logic [31:0] pc, ins;
        do_reset(2);
        if_ready = 1'b1;
        repeat (6) @(negedge clk);
        tests++; if (if_valid !== 1'b1) begin fails++; $display("FAIL mr_streaming: got if_valid %b expected 1", if_valid); end
        rst = 1'b0;
        #1;
        tests++; if (imem_req_valid !== 1'b0 || if_valid !== 1'b0 || fetch_err !== 1'b0) begin fails++; $display("FAIL mr_ctrl: got req=%b if_valid=%b err=%b expected 0", imem_req_valid, if_valid, fetch_err); end
        tests++; if (if_pc !== 32'h0 || if_instr !== 32'h0) begin fails++; $display("FAIL mr_data: got pc=%h instr=%h expected 0", if_pc, if_instr); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #2;
        tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin fails++; $display("FAIL mr_restart: got v=%b addr=%h expected v=1 addr=0", imem_req_valid, imem_req_addr); end
        pop_one(got, pc, ins);
        tests++; if (!got || pc !== 32'h0 || ins !== data_of(32'h0)) begin fails++; $display("FAIL mr_first_pc: got %h/%h expected 00000000", pc, ins); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_drop();
        test_redirect_pop();
        test_misalign();
        test_wrap();
        test_midstream_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
